cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
- Exception/interrupt sequencer that sits between the MEM/WB pipeline boundary and the CP0 register file.
- Accepts at most one exception or ERET per instruction, prioritises interrupt against the instruction exception causes, and squashes the excepting instruction.
- Drives the single CP0 write port through the EPC, Cause and Status updates in sequence, then redirects the PC.
- In IDLE, owns the CP0 write-port mux and passes pipeline MTC0 writes through.

Parameters:
- EXC_VECTOR, 32'h0000_0020, handler entry address.
- PC_W, 32, PC/data width; matches RegBus.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_valid_i  in  1  MEM holds a real, non-bubble instruction.
- mem_pc_i  in  32  PC of MEM instruction.
- mem_in_ds_i  in  1  MEM instruction is in a branch delay slot.
- mem_exc_i  in  5  cause bits: [0] syscall, [1] reserved instruction, [2] overflow, [3] trap, [4] eret.
- status_i  in  32  current CP0 Status.
- cause_i  in  32  current CP0 Cause.
- epc_i  in  32  current CP0 EPC.
- pipe_we_i  in  1  WB-stage MTC0 write enable.
- pipe_waddr_i  in  5  MTC0 register address.
- pipe_data_i  in  32  MTC0 data.
- cp0_we_o  out  1  CP0 write enable.
- cp0_waddr_o  out  5  CP0 write address.
- cp0_data_o  out  32  CP0 write data.
- flush_o  out  1  squash the MEM instruction and everything younger.
- stall_o  out  1  freeze the pipeline.
- redirect_o  out  1  load new_pc_o into the PC.
- new_pc_o  out  32  redirect target.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; every output and all latched registers are 0.
- Interrupt pending (int_pend):
  - (cause_i[15:8] & status_i[15:8]) != 0, and
  - status_i[0]=1 (IE), and
  - status_i[1]=0 (EXL), and
  - mem_valid_i=1.
- Priority, highest first; the winner is "accepted" in IDLE:
  - int_pend → ExcCode 0
  - syscall → 8
  - reserved instruction → 10
  - overflow → 12
  - trap → 13
  - eret
- Acceptance cycle N, IDLE only:
  - flush_o=1 combinationally.
  - Latch ExcCode, BD=mem_in_ds_i, and EPC value = mem_in_ds_i ? mem_pc_i-4 : mem_pc_i (mod 2^32).
  - Latch the status snapshot and the EPC snapshot for eret.
- Forwarding of snapshots: if pipe_we_i=1 in cycle N and pipe_waddr_i equals the STATUS (resp. EPC) address, the snapshot takes pipe_data_i instead of status_i (resp. epc_i).
- CP0 write port in IDLE:
  - cp0_we_o/waddr/data = pipe_we_i/waddr/data, including in the acceptance cycle, because the WB MTC0 is older.
  - In every other state, pipeline writes are ignored; the pipeline is stalled.
- FSM states: IDLE, W_EPC, W_CAUSE, W_STATUS, REDIRECT.
- Exception path: IDLE → W_EPC → W_CAUSE → W_STATUS → REDIRECT → IDLE.
  - W_EPC: write EPC = latched EPC value.
  - W_CAUSE: write Cause = cause_i with bit31=BD and [6:2]=ExcCode, all other bits unchanged. The CP0 file accepts bits 31 and 6:2 on this write.
  - W_STATUS: write Status = snapshot with bit1 (EXL)=1.
  - REDIRECT: redirect_o=1, new_pc_o=EXC_VECTOR.
- ERET path: IDLE → W_STATUS → REDIRECT → IDLE.
  - W_STATUS: write Status = snapshot with bit1 (EXL)=0.
  - REDIRECT: redirect_o=1, new_pc_o = EPC snapshot.
- Handshake signals:
  - stall_o=1 in all non-IDLE states.
  - flush_o is only ever asserted in the acceptance cycle.
  - redirect_o is asserted for exactly one cycle.
- Latency: acceptance to redirect is 4 cycles for an exception and 2 cycles for eret.
- New requests arriving in non-IDLE states are ignored; the pipeline is frozen, so they are re-presented after IDLE.
- Reset asserted mid-sequence returns the FSM to IDLE immediately. Partial CP0 writes are not rolled back.
- mem_valid_i=0 gives no acceptance even if mem_exc_i≠0.

Decomposition:
- Shared package/defines file holds:
  - ExcCode constants: EXC_INT, EXC_SYS, EXC_RI, EXC_OV, EXC_TR.
  - mem_exc_i bit indices.
  - CP0 register addresses.
  - Status/Cause bit positions: IE, EXL, BD, ExcCode field.
  - FSM state encoding.
- One natural sub-module, cp0_exc_prio: combinational priority encoder from int_pend and mem_exc_i to {accept, is_eret, exccode}.

Test Plan:
- Syscall: pc=0x100, not in delay slot, Status=0x0000_0001, no MTC0.
  - N: flush_o=1.
  - N+1: EPC←0x100.
  - N+2: Cause[6:2]←8, BD=0.
  - N+3: Status←0x0000_0003.
  - N+4: redirect_o=1, new_pc_o=0x20.
- Overflow in delay slot at pc=0x204 → EPC←0x200, Cause bit31=1, ExcCode 12.
- Interrupt plus reserved instruction in the same cycle, with Cause[10]=1, Status=0x0000_0401 → ExcCode 0 wins. Repeat with Status EXL=1 → ExcCode 10.
- ERET with epc_i=0x300, Status=0x3, and a simultaneous WB MTC0 to EPC with data 0x400.
  - N: the pipe write passes through the port.
  - N+1: Status←0x1.
  - N+2: redirect_o=1, new_pc_o=0x400.
- Reset asserted in W_CAUSE → all outputs 0 with no clock edge needed. After release, IDLE passes an MTC0 write to Compare through the port unchanged.
- mem_valid_i=0 with mem_exc_i=5'b00001 → no flush_o and no stall_o. The FSM stays in IDLE.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared constants for the CP0 exception sequencer: cause codes, request bits,
// CP0 register addresses, Status/Cause field positions and FSM encoding.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;
    localparam logic [4:0] EXC_TR  = 5'd13;

    localparam int EXB_SYS  = 0;
    localparam int EXB_RI   = 1;
    localparam int EXB_OV   = 2;
    localparam int EXB_TR   = 3;
    localparam int EXB_ERET = 4;

    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam int ST_IE      = 0;
    localparam int ST_EXL     = 1;
    localparam int CA_BD      = 31;
    localparam int CA_EXC_LO  = 2;
    localparam int CA_EXC_HI  = 6;
    localparam int IRQ_LO     = 8;
    localparam int IRQ_HI     = 15;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_EPC    = 3'd1,
        S_W_CAUSE  = 3'd2,
        S_W_STATUS = 3'd3,
        S_REDIRECT = 3'd4
    } state_t;

endpackage

// File: rtl/cp0_exc_prio.sv
// Fixed-priority pick between a pending interrupt and the instruction's
// exception/ERET request bits.
module cp0_exc_prio
    import cp0_exc_ctrl_pkg::*;
(
    input  logic       int_pend,
    input  logic [4:0] exc,
    output logic       accept,
    output logic       is_eret,
    output logic [4:0] exccode
);

    always_comb begin
        accept  = 1'b1;
        is_eret = 1'b0;
        exccode = EXC_INT;
        if (int_pend)            exccode = EXC_INT;
        else if (exc[EXB_SYS])   exccode = EXC_SYS;
        else if (exc[EXB_RI])    exccode = EXC_RI;
        else if (exc[EXB_OV])    exccode = EXC_OV;
        else if (exc[EXB_TR])    exccode = EXC_TR;
        else if (exc[EXB_ERET])  is_eret = 1'b1;
        else                     accept  = 1'b0;
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Exception/ERET sequencer: owns the CP0 write port, walks EPC/Cause/Status
// updates one per cycle, then redirects the PC.
//
// state      | meaning
// S_IDLE     | pass pipeline MTC0 writes through, accept a new request
// S_W_EPC    | write latched EPC value
// S_W_CAUSE  | write Cause with BD and ExcCode merged in
// S_W_STATUS | write Status snapshot with EXL set (exception) or cleared (eret)
// S_REDIRECT | one-cycle PC redirect to the vector or the EPC snapshot
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid_i,
    input  logic [PC_W-1:0] mem_pc_i,
    input  logic            mem_in_ds_i,
    input  logic [4:0]      mem_exc_i,
    input  logic [PC_W-1:0] status_i,
    input  logic [PC_W-1:0] cause_i,
    input  logic [PC_W-1:0] epc_i,
    input  logic            pipe_we_i,
    input  logic [4:0]      pipe_waddr_i,
    input  logic [PC_W-1:0] pipe_data_i,
    output logic            cp0_we_o,
    output logic [4:0]      cp0_waddr_o,
    output logic [PC_W-1:0] cp0_data_o,
    output logic            flush_o,
    output logic            stall_o,
    output logic            redirect_o,
    output logic [PC_W-1:0] new_pc_o
);

    state_t          state;
    logic [4:0]      code_q;
    logic            bd_q;
    logic            eret_q;
    logic [PC_W-1:0] epcv_q;
    logic [PC_W-1:0] status_snap_q;
    logic [PC_W-1:0] epc_snap_q;

    logic            int_pend;
    logic [4:0]      exc_v;
    logic            accept;
    logic            is_eret;
    logic [4:0]      exccode;
    logic [PC_W-1:0] status_fwd;
    logic [PC_W-1:0] epc_fwd;

    assign int_pend = (|(cause_i[IRQ_HI:IRQ_LO] & status_i[IRQ_HI:IRQ_LO]))
                    & status_i[ST_IE] & ~status_i[ST_EXL] & mem_valid_i;
    assign exc_v    = mem_valid_i ? mem_exc_i : 5'd0;

    cp0_exc_prio u_prio (
        .int_pend (int_pend),
        .exc      (exc_v),
        .accept   (accept),
        .is_eret  (is_eret),
        .exccode  (exccode)
    );

    // The WB-stage MTC0 is older than the MEM instruction, so its value wins.
    assign status_fwd = (pipe_we_i && pipe_waddr_i == CP0_STATUS) ? pipe_data_i : status_i;
    assign epc_fwd    = (pipe_we_i && pipe_waddr_i == CP0_EPC)    ? pipe_data_i : epc_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            code_q        <= '0;
            bd_q          <= 1'b0;
            eret_q        <= 1'b0;
            epcv_q        <= '0;
            status_snap_q <= '0;
            epc_snap_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        code_q        <= exccode;
                        bd_q          <= mem_in_ds_i;
                        eret_q        <= is_eret;
                        epcv_q        <= mem_in_ds_i ? mem_pc_i - PC_W'(4) : mem_pc_i;
                        status_snap_q <= status_fwd;
                        epc_snap_q    <= epc_fwd;
                        state         <= is_eret ? S_W_STATUS : S_W_EPC;
                    end
                end
                S_W_EPC:    state <= S_W_CAUSE;
                S_W_CAUSE:  state <= S_W_STATUS;
                S_W_STATUS: state <= S_REDIRECT;
                S_REDIRECT: state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        cp0_we_o    = 1'b0;
        cp0_waddr_o = 5'd0;
        cp0_data_o  = '0;
        flush_o     = 1'b0;
        redirect_o  = 1'b0;
        new_pc_o    = '0;
        stall_o     = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                // Gated by rst so every output reads 0 while reset is held.
                if (rst) begin
                    cp0_we_o    = pipe_we_i;
                    cp0_waddr_o = pipe_waddr_i;
                    cp0_data_o  = pipe_data_i;
                    flush_o     = accept;
                end
            end
            S_W_EPC: begin
                cp0_we_o    = 1'b1;
                cp0_waddr_o = CP0_EPC;
                cp0_data_o  = epcv_q;
            end
            S_W_CAUSE: begin
                cp0_we_o                        = 1'b1;
                cp0_waddr_o                     = CP0_CAUSE;
                cp0_data_o                      = cause_i;
                cp0_data_o[CA_BD]               = bd_q;
                cp0_data_o[CA_EXC_HI:CA_EXC_LO] = code_q;
            end
            S_W_STATUS: begin
                cp0_we_o           = 1'b1;
                cp0_waddr_o        = CP0_STATUS;
                cp0_data_o         = status_snap_q;
                cp0_data_o[ST_EXL] = ~eret_q;
            end
            S_REDIRECT: begin
                redirect_o = 1'b1;
                new_pc_o   = eret_q ? epc_snap_q : EXC_VECTOR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Randomized bench for cp0_exc_ctrl against a queue-of-expected-writes model.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_pc_i = '0;
    logic        mem_in_ds_i = 1'b0;
    logic [4:0]  mem_exc_i = '0;
    logic [31:0] status_i = '0;
    logic [31:0] cause_i = '0;
    logic [31:0] epc_i = '0;
    logic        pipe_we_i = 1'b0;
    logic [4:0]  pipe_waddr_i = '0;
    logic [31:0] pipe_data_i = '0;
    logic        cp0_we_o;
    logic [4:0]  cp0_waddr_o;
    logic [31:0] cp0_data_o;
    logic        flush_o;
    logic        stall_o;
    logic        redirect_o;
    logic [31:0] new_pc_o;

    int n_checks = 0;
    int n_errors = 0;

    cp0_exc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid_i  (mem_valid_i),
        .mem_pc_i     (mem_pc_i),
        .mem_in_ds_i  (mem_in_ds_i),
        .mem_exc_i    (mem_exc_i),
        .status_i     (status_i),
        .cause_i      (cause_i),
        .epc_i        (epc_i),
        .pipe_we_i    (pipe_we_i),
        .pipe_waddr_i (pipe_waddr_i),
        .pipe_data_i  (pipe_data_i),
        .cp0_we_o     (cp0_we_o),
        .cp0_waddr_o  (cp0_waddr_o),
        .cp0_data_o   (cp0_data_o),
        .flush_o      (flush_o),
        .stall_o      (stall_o),
        .redirect_o   (redirect_o),
        .new_pc_o     (new_pc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One expected cycle of a pending sequence.
    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        is_cause;
        logic        bd;
        logic [4:0]  code;
        logic        redir;
        logic [31:0] npc;
    } exp_t;

    exp_t q[$];

    function automatic exp_t mk(logic we, logic [4:0] addr, logic [31:0] data, logic is_cause,
                                logic bd, logic [4:0] code, logic redir, logic [31:0] npc);
        exp_t e;
        e.we = we; e.addr = addr; e.data = data; e.is_cause = is_cause;
        e.bd = bd; e.code = code; e.redir = redir; e.npc = npc;
        return e;
    endfunction

    // Evaluate what this cycle must show given the current inputs, then compare.
    task automatic model_check();
        exp_t        e;
        logic        ipend;
        logic        acc;
        logic        eret;
        logic [4:0]  code;
        logic [31:0] ssnap;
        logic [31:0] esnap;
        logic [31:0] d;
        if (q.size() > 0) begin
            e = q.pop_front();
            d = e.data;
            if (e.is_cause) d = {e.bd, cause_i[30:7], e.code, cause_i[1:0]};
            chk("busy_we", {31'd0, cp0_we_o}, {31'd0, e.we});
            if (e.we) begin
                chk("busy_addr", {27'd0, cp0_waddr_o}, {27'd0, e.addr});
                chk("busy_data", cp0_data_o, d);
            end
            chk("busy_flush", {31'd0, flush_o}, 32'd0);
            chk("busy_stall", {31'd0, stall_o}, 32'd1);
            chk("busy_redirect", {31'd0, redirect_o}, {31'd0, e.redir});
            if (e.redir) chk("new_pc", new_pc_o, e.npc);
        end else begin
            ipend = ((cause_i[15:8] & status_i[15:8]) != 8'd0) && status_i[0] && !status_i[1]
                    && mem_valid_i;
            acc  = mem_valid_i && (ipend || mem_exc_i != 5'd0);
            eret = 1'b0;
            code = 5'd0;
            if (ipend)             code = 5'd0;
            else if (mem_exc_i[0]) code = 5'd8;
            else if (mem_exc_i[1]) code = 5'd10;
            else if (mem_exc_i[2]) code = 5'd12;
            else if (mem_exc_i[3]) code = 5'd13;
            else                   eret = 1'b1;
            chk("idle_we", {31'd0, cp0_we_o}, {31'd0, pipe_we_i});
            chk("idle_addr", {27'd0, cp0_waddr_o}, {27'd0, pipe_waddr_i});
            chk("idle_data", cp0_data_o, pipe_data_i);
            chk("idle_flush", {31'd0, flush_o}, {31'd0, acc});
            chk("idle_stall", {31'd0, stall_o}, 32'd0);
            chk("idle_redirect", {31'd0, redirect_o}, 32'd0);
            if (acc) begin
                ssnap = (pipe_we_i && pipe_waddr_i == 5'd12) ? pipe_data_i : status_i;
                esnap = (pipe_we_i && pipe_waddr_i == 5'd14) ? pipe_data_i : epc_i;
                if (eret) begin
                    q.push_back(mk(1, 5'd12, ssnap & ~32'd2, 0, 0, 0, 0, 0));
                    q.push_back(mk(0, 5'd0, 0, 0, 0, 0, 1, esnap));
                end else begin
                    q.push_back(mk(1, 5'd14, mem_in_ds_i ? mem_pc_i - 32'd4 : mem_pc_i,
                                   0, 0, 0, 0, 0));
                    q.push_back(mk(1, 5'd13, 0, 1, mem_in_ds_i, code, 0, 0));
                    q.push_back(mk(1, 5'd12, ssnap | 32'd2, 0, 0, 0, 0, 0));
                    q.push_back(mk(0, 5'd0, 0, 0, 0, 0, 1, 32'h20));
                end
            end
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic ds, input logic [4:0] exc,
                         input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep,
                         input logic pwe, input logic [4:0] pwa, input logic [31:0] pd);
        @(posedge clk);
        #1;
        mem_valid_i = v; mem_pc_i = pc; mem_in_ds_i = ds; mem_exc_i = exc;
        status_i = st; cause_i = ca; epc_i = ep;
        pipe_we_i = pwe; pipe_waddr_i = pwa; pipe_data_i = pd;
        #2;
        model_check();
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 32'h1, 0, 0, 0, 0, 0);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_we"}, {31'd0, cp0_we_o}, 32'd0);
        chk({tag, "_addr"}, {27'd0, cp0_waddr_o}, 32'd0);
        chk({tag, "_data"}, cp0_data_o, 32'd0);
        chk({tag, "_flush"}, {31'd0, flush_o}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
        chk({tag, "_redirect"}, {31'd0, redirect_o}, 32'd0);
        chk({tag, "_new_pc"}, new_pc_o, 32'd0);
    endtask

    initial begin
        logic [4:0]  pwa;
        logic [4:0]  exc;
        int          r;

        repeat (2) @(posedge clk);
        #2;
        all_zero("reset");
        rst = 1'b1;

        // Syscall at 0x100, not in a delay slot.
        drive(1, 32'h100, 0, 5'b00001, 32'h1, 0, 0, 0, 0, 0);
        chk("sys_flush", {31'd0, flush_o}, 32'd1);
        drive(0, 0, 0, 0, 32'h1, 0, 0, 0, 0, 0);
        chk("sys_epc", cp0_data_o, 32'h100);
        drive(0, 0, 0, 0, 32'h1, 0, 0, 0, 0, 0);
        chk("sys_cause", cp0_data_o, 32'h0000_0020);
        drive(0, 0, 0, 0, 32'h1, 0, 0, 0, 0, 0);
        chk("sys_status", cp0_data_o, 32'h3);
        drive(0, 0, 0, 0, 32'h1, 0, 0, 0, 0, 0);
        chk("sys_redirect", new_pc_o, 32'h20);
        quiet(1);

        // Overflow in a delay slot.
        drive(1, 32'h204, 1, 5'b00100, 32'h1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 32'h1, 0, 0, 0, 0, 0);
        chk("ov_epc", cp0_data_o, 32'h200);
        drive(0, 0, 0, 0, 32'h1, 0, 0, 0, 0, 0);
        chk("ov_cause", cp0_data_o, 32'h8000_0030);
        quiet(3);

        // Interrupt beats reserved instruction; with EXL set the RI wins instead.
        drive(1, 32'h300, 0, 5'b00010, 32'h401, 32'h400, 0, 0, 0, 0);
        quiet(1);
        drive(0, 0, 0, 0, 32'h401, 32'h400, 0, 0, 0, 0);
        chk("int_code", {27'd0, cp0_data_o[6:2]}, 32'd0);
        quiet(3);
        drive(1, 32'h300, 0, 5'b00010, 32'h403, 32'h400, 0, 0, 0, 0);
        quiet(1);
        drive(0, 0, 0, 0, 32'h403, 32'h400, 0, 0, 0, 0);
        chk("ri_code", {27'd0, cp0_data_o[6:2]}, 32'd10);
        quiet(3);

        // ERET with a same-cycle MTC0 to EPC.
        drive(1, 32'h500, 0, 5'b10000, 32'h3, 0, 32'h300, 1, 5'd14, 32'h400);
        chk("eret_pass", cp0_data_o, 32'h400);
        drive(0, 0, 0, 0, 32'h3, 0, 32'h300, 0, 0, 0);
        chk("eret_status", cp0_data_o, 32'h1);
        drive(0, 0, 0, 0, 32'h3, 0, 32'h300, 0, 0, 0);
        chk("eret_newpc", new_pc_o, 32'h400);
        quiet(1);

        // Reset while writing Cause.
        drive(1, 32'h100, 0, 5'b00001, 32'h1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 32'h1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 32'h1, 0, 0, 0, 0, 0);
        chk("mid_cause_addr", {27'd0, cp0_waddr_o}, 32'd13);
        rst = 1'b0;
        #1;
        all_zero("midrst");
        q.delete();
        @(posedge clk);
        #2 rst = 1'b1;
        drive(0, 0, 0, 0, 32'h1, 0, 0, 1, 5'd11, 32'hDEAD_BEEF);
        chk("compare_addr", {27'd0, cp0_waddr_o}, 32'd11);
        chk("compare_data", cp0_data_o, 32'hDEAD_BEEF);

        // Invalid instruction carrying a syscall request.
        drive(0, 32'h100, 0, 5'b00001, 32'h1, 0, 0, 0, 0, 0);
        chk("inv_flush", {31'd0, flush_o}, 32'd0);
        quiet(1);
        chk("inv_stall", {31'd0, stall_o}, 32'd0);

        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)       exc = 5'(1 << r);
            else if (r == 5) exc = 5'($urandom);
            else             exc = 5'd0;
            case ($urandom_range(0, 4))
                0: pwa = 5'd11;
                1: pwa = 5'd12;
                2: pwa = 5'd13;
                3: pwa = 5'd14;
                default: pwa = 5'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1, exc,
                  $urandom,
                  ($urandom & 32'hFFFF_00FF) | (($urandom_range(0, 2) == 0) ? ($urandom & 32'hFF00) : 32'd0),
                  $urandom, $urandom_range(0, 2) == 0, pwa, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
